// File: rtl/sv32_ptw_refill.sv
// Single-walker Sv32 page-table walker producing TLB refill entries.
// Fetches up to two PTEs over a valid/ready port and returns one registered entry per miss.
module sv32_ptw_refill #(
  parameter int PTE_BYTES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [19:0] io_req_vpn,
  input  logic [19:0] io_satp_ppn,
  output logic        io_mem_req_valid,
  input  logic        io_mem_req_ready,
  output logic [31:0] io_mem_req_addr,
  input  logic        io_mem_resp_valid,
  input  logic [31:0] io_mem_resp_data,
  input  logic        io_mem_resp_ae,
  input  logic        io_pma_r,
  input  logic        io_pma_w,
  input  logic        io_pma_x,
  input  logic        io_pma_ppp,
  input  logic        io_pma_pal,
  input  logic        io_pma_paa,
  input  logic        io_pma_eff,
  input  logic        io_pma_c,
  output logic        io_resp_valid,
  input  logic        io_resp_ready,
  output logic        io_resp_level,
  output logic [19:0] io_resp_ppn,
  output logic        io_resp_u,
  output logic        io_resp_ae_ptw,
  output logic        io_resp_ae_final,
  output logic        io_resp_pf,
  output logic        io_resp_gf,
  output logic        io_resp_sw,
  output logic        io_resp_sx,
  output logic        io_resp_sr,
  output logic        io_resp_pw,
  output logic        io_resp_px,
  output logic        io_resp_pr,
  output logic        io_resp_ppp,
  output logic        io_resp_pal,
  output logic        io_resp_paa,
  output logic        io_resp_eff,
  output logic        io_resp_c
);

  typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_t;

  typedef struct packed {
    logic        level;
    logic [19:0] ppn;
    logic        u, ae_ptw, ae_final, pf, gf, sw, sx, sr, pw, px, pr;
    logic        ppp, pal, paa, eff, c;
  } entry_t;

  state_t      state_q, state_d;
  logic [19:0] vpn_q, vpn_d;
  logic [19:0] table_q, table_d;
  logic        level_q, level_d;
  entry_t      entry_q, entry_d;
  entry_t      dec;

  logic [31:0] pte;
  logic        pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_d;
  logic [31:0] idx;
  logic [31:0] addr;
  logic        unused_pte_bits;

  assign pte   = io_mem_resp_data;
  assign pte_v = pte[0];
  assign pte_r = pte[1];
  assign pte_w = pte[2];
  assign pte_x = pte[3];
  assign pte_u = pte[4];
  assign pte_a = pte[6];
  assign pte_d = pte[7];
  assign unused_pte_bits = ^{pte[9:8], pte[5]};

  // 32-bit address arithmetic; any carry out of bit 31 is discarded.
  assign idx  = {22'b0, (level_q ? vpn_q[19:10] : vpn_q[9:0])};
  assign addr = {table_q, 12'b0} + idx * 32'(PTE_BYTES);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      vpn_q   <= '0;
      table_q <= '0;
      level_q <= 1'b0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      vpn_q   <= vpn_d;
      table_q <= table_d;
      level_q <= level_d;
      entry_q <= entry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vpn_d   = vpn_q;
    table_d = table_q;
    level_d = level_q;
    entry_d = entry_q;
    dec     = '0;
    case (state_q)
      IDLE: begin
        if (io_req_valid) begin
          vpn_d   = io_req_vpn;
          table_d = io_satp_ppn;
          level_d = 1'b1;
          state_d = MREQ;
        end
      end
      MREQ: begin
        if (io_mem_req_ready) state_d = MWAIT;
      end
      MWAIT: begin
        if (io_mem_resp_valid) begin
          dec.level = level_q;
          state_d   = RESP;
          if (io_mem_resp_ae) begin
            dec.ae_ptw   = level_q;
            dec.ae_final = ~level_q;
          end else if (!pte_v || (pte_w && !pte_r) || (pte[31:30] != 2'b00)) begin
            dec.pf = 1'b1;
          end else if (pte_r || pte_x) begin
            // A level-1 leaf must be 4 MiB aligned: its low PPN slice has to be zero.
            if (level_q && (pte[19:10] != 10'b0)) begin
              dec.pf = 1'b1;
            end else begin
              dec.ppn = level_q ? {pte[29:20], vpn_q[9:0]} : pte[29:10];
              dec.u   = pte_u;
              dec.sr  = pte_r & pte_a;
              dec.sw  = pte_w & pte_d & pte_a;
              dec.sx  = pte_x & pte_a;
              dec.pr  = io_pma_r;
              dec.pw  = io_pma_w;
              dec.px  = io_pma_x;
              dec.ppp = io_pma_ppp;
              dec.pal = io_pma_pal;
              dec.paa = io_pma_paa;
              dec.eff = io_pma_eff;
              dec.c   = io_pma_c;
            end
          end else if (level_q) begin
            table_d = pte[29:10];
            level_d = 1'b0;
            state_d = MREQ;
          end else begin
            dec.pf = 1'b1;
          end
          if (state_d == RESP) entry_d = dec;
        end
      end
      RESP: begin
        if (io_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign io_req_ready     = (state_q == IDLE);
  assign io_mem_req_valid = (state_q == MREQ);
  assign io_mem_req_addr  = (state_q == MREQ) ? addr : 32'b0;
  assign io_resp_valid    = (state_q == RESP);
  assign io_resp_level    = entry_q.level;
  assign io_resp_ppn      = entry_q.ppn;
  assign io_resp_u        = entry_q.u;
  assign io_resp_ae_ptw   = entry_q.ae_ptw;
  assign io_resp_ae_final = entry_q.ae_final;
  assign io_resp_pf       = entry_q.pf;
  assign io_resp_gf       = entry_q.gf;
  assign io_resp_sw       = entry_q.sw;
  assign io_resp_sx       = entry_q.sx;
  assign io_resp_sr       = entry_q.sr;
  assign io_resp_pw       = entry_q.pw;
  assign io_resp_px       = entry_q.px;
  assign io_resp_pr       = entry_q.pr;
  assign io_resp_ppp      = entry_q.ppp;
  assign io_resp_pal      = entry_q.pal;
  assign io_resp_paa      = entry_q.paa;
  assign io_resp_eff      = entry_q.eff;
  assign io_resp_c        = entry_q.c;

endmodule

// File: tb/tb_sv32_ptw_refill.sv
// Scoreboard bench for sv32_ptw_refill: directed walks with a bench-side memory responder.
module tb_sv32_ptw_refill;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_req_valid, io_req_ready;
  logic [19:0] io_req_vpn, io_satp_ppn;
  logic        io_mem_req_valid, io_mem_req_ready;
  logic [31:0] io_mem_req_addr;
  logic        io_mem_resp_valid, io_mem_resp_ae;
  logic [31:0] io_mem_resp_data;
  logic        io_pma_r, io_pma_w, io_pma_x, io_pma_ppp, io_pma_pal, io_pma_paa, io_pma_eff, io_pma_c;
  logic        io_resp_valid, io_resp_ready, io_resp_level;
  logic [19:0] io_resp_ppn;
  logic        io_resp_u, io_resp_ae_ptw, io_resp_ae_final, io_resp_pf, io_resp_gf;
  logic        io_resp_sw, io_resp_sx, io_resp_sr, io_resp_pw, io_resp_px, io_resp_pr;
  logic        io_resp_ppp, io_resp_pal, io_resp_paa, io_resp_eff, io_resp_c;

  int checks = 0;
  int failures = 0;
  logic [36:0] sb[$];
  logic [36:0] got;

  always #5 clock = ~clock;

  sv32_ptw_refill #(.PTE_BYTES(4)) dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_vpn(io_req_vpn), .io_satp_ppn(io_satp_ppn),
    .io_mem_req_valid(io_mem_req_valid), .io_mem_req_ready(io_mem_req_ready),
    .io_mem_req_addr(io_mem_req_addr),
    .io_mem_resp_valid(io_mem_resp_valid), .io_mem_resp_data(io_mem_resp_data),
    .io_mem_resp_ae(io_mem_resp_ae),
    .io_pma_r(io_pma_r), .io_pma_w(io_pma_w), .io_pma_x(io_pma_x),
    .io_pma_ppp(io_pma_ppp), .io_pma_pal(io_pma_pal), .io_pma_paa(io_pma_paa),
    .io_pma_eff(io_pma_eff), .io_pma_c(io_pma_c),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_level(io_resp_level), .io_resp_ppn(io_resp_ppn),
    .io_resp_u(io_resp_u), .io_resp_ae_ptw(io_resp_ae_ptw), .io_resp_ae_final(io_resp_ae_final),
    .io_resp_pf(io_resp_pf), .io_resp_gf(io_resp_gf),
    .io_resp_sw(io_resp_sw), .io_resp_sx(io_resp_sx), .io_resp_sr(io_resp_sr),
    .io_resp_pw(io_resp_pw), .io_resp_px(io_resp_px), .io_resp_pr(io_resp_pr),
    .io_resp_ppp(io_resp_ppp), .io_resp_pal(io_resp_pal), .io_resp_paa(io_resp_paa),
    .io_resp_eff(io_resp_eff), .io_resp_c(io_resp_c)
  );

  assign got = {io_resp_level, io_resp_ppn, io_resp_u, io_resp_ae_ptw, io_resp_ae_final,
                io_resp_pf, io_resp_gf, io_resp_sw, io_resp_sx, io_resp_sr,
                io_resp_pw, io_resp_px, io_resp_pr,
                io_resp_ppp, io_resp_pal, io_resp_paa, io_resp_eff, io_resp_c};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [36:0] leaf_e(input logic lvl, input logic [19:0] ppn, input logic u,
                                         input logic sw, input logic sx, input logic sr);
    return {lvl, ppn, u, 3'b000, 1'b0, sw, sx, sr, io_pma_w, io_pma_x, io_pma_r,
            io_pma_ppp, io_pma_pal, io_pma_paa, io_pma_eff, io_pma_c};
  endfunction

  function automatic logic [36:0] fault_e(input logic lvl, input logic ae_ptw,
                                          input logic ae_final, input logic pf);
    return {lvl, 20'b0, 1'b0, ae_ptw, ae_final, pf, 12'b0};
  endfunction

  task automatic serve(input logic [31:0] a, input logic [31:0] data, input logic ae, input bit bp);
    for (int k = 0; k < 20 && io_mem_req_valid !== 1'b1; k++) tick();
    check("mreq_valid", io_mem_req_valid, 1'b1);
    check("mreq_addr", io_mem_req_addr, a);
    if (bp) begin
      repeat (5) begin
        tick();
        check("mreq_addr_hold", io_mem_req_addr, a);
        check("req_blocked", io_req_ready, 1'b0);
      end
    end
    io_mem_req_ready = 1'b1;
    tick();
    io_mem_req_ready = 1'b0;
    tick();
    io_mem_resp_valid = 1'b1;
    io_mem_resp_data  = data;
    io_mem_resp_ae    = ae;
    tick();
    io_mem_resp_valid = 1'b0;
    io_mem_resp_ae    = 1'b0;
    io_mem_resp_data  = 32'hDEADBEEF;
  endtask

  task automatic walk(input logic [19:0] vpn, input logic [19:0] satp, input int n,
                      input logic [31:0] p0, input logic [31:0] p1,
                      input logic ae0, input logic ae1,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [36:0] expv, input bit bp);
    logic [36:0] e;
    sb.push_back(expv);
    check("req_ready_idle", io_req_ready, 1'b1);
    io_req_valid = 1'b1;
    io_req_vpn   = vpn;
    io_satp_ppn  = satp;
    tick();
    io_req_valid = 1'b0;
    io_satp_ppn  = 20'h5A5A5;
    if (bp) begin
      io_req_valid = 1'b1;
      io_req_vpn   = 20'hABCDE;
    end
    serve(a0, p0, ae0, bp);
    if (n > 1) serve(a1, p1, ae1, bp);
    for (int k = 0; k < 20 && io_resp_valid !== 1'b1; k++) tick();
    check("resp_valid", io_resp_valid, 1'b1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check("entry", got, e);
      if (bp) begin
        repeat (3) begin
          tick();
          check("entry_hold", got, e);
          check("resp_valid_hold", io_resp_valid, 1'b1);
          check("req_blocked_resp", io_req_ready, 1'b0);
        end
      end
    end
    io_req_valid  = 1'b0;
    io_resp_ready = 1'b1;
    tick();
    io_resp_ready = 1'b0;
    check("resp_done", io_resp_valid, 1'b0);
    check("req_ready_back", io_req_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    io_req_valid = 1'b0; io_req_vpn = '0; io_satp_ppn = '0;
    io_mem_req_ready = 1'b0; io_mem_resp_valid = 1'b0; io_mem_resp_data = '0; io_mem_resp_ae = 1'b0;
    io_resp_ready = 1'b0;
    {io_pma_r, io_pma_w, io_pma_x, io_pma_ppp, io_pma_pal, io_pma_paa, io_pma_eff, io_pma_c} = 8'b1101_0101;
    repeat (3) tick();
    check("rst_req_ready", io_req_ready, 1'b1);
    check("rst_mreq_valid", io_mem_req_valid, 1'b0);
    check("rst_mreq_addr", io_mem_req_addr, 32'h0);
    check("rst_resp_valid", io_resp_valid, 1'b0);
    check("rst_entry", got, 37'h0);
    reset = 1'b0;
    tick();

    // 4 KiB walk
    walk(20'h12345, 20'h00080, 2, 32'h20000001, 32'h123450CF, 1'b0, 1'b0,
         32'h00080120, 32'h80000D14, leaf_e(1'b0, 20'h48D14, 1'b0, 1'b1, 1'b1, 1'b1), 1'b0);
    // Superpage with memory and response backpressure
    walk(20'h12345, 20'h00080, 1, 32'h1000004B, 32'h0, 1'b0, 1'b0,
         32'h00080120, 32'h0, leaf_e(1'b1, 20'h40345, 1'b0, 1'b0, 1'b1, 1'b1), 1'b1);
    // Misaligned superpage
    walk(20'h12345, 20'h00080, 1, 32'h1000044B, 32'h0, 1'b0, 1'b0,
         32'h00080120, 32'h0, fault_e(1'b1, 1'b0, 1'b0, 1'b1), 1'b0);
    // Access errors at each level
    walk(20'h12345, 20'h00080, 1, 32'h1000004B, 32'h0, 1'b1, 1'b0,
         32'h00080120, 32'h0, fault_e(1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
    walk(20'h12345, 20'h00080, 2, 32'h20000001, 32'h123450CF, 1'b0, 1'b1,
         32'h00080120, 32'h80000D14, fault_e(1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
    // Non-leaf at level 0, W without R, reserved high bits
    walk(20'h12345, 20'h00080, 2, 32'h20000001, 32'h00000001, 1'b0, 1'b0,
         32'h00080120, 32'h80000D14, fault_e(1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
    walk(20'h12345, 20'h00080, 1, 32'h00000005, 32'h0, 1'b0, 1'b0,
         32'h00080120, 32'h0, fault_e(1'b1, 1'b0, 1'b0, 1'b1), 1'b0);
    walk(20'h12345, 20'h00080, 1, 32'h8000004B, 32'h0, 1'b0, 1'b0,
         32'h00080120, 32'h0, fault_e(1'b1, 1'b0, 1'b0, 1'b1), 1'b0);
    // A clear: leaf with no effective permissions
    walk(20'h12345, 20'h00080, 1, 32'h1000000B, 32'h0, 1'b0, 1'b0,
         32'h00080120, 32'h0, leaf_e(1'b1, 20'h40345, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    // Top-of-memory table, user page, different PMA pattern
    {io_pma_r, io_pma_w, io_pma_x, io_pma_ppp, io_pma_pal, io_pma_paa, io_pma_eff, io_pma_c} = 8'b0110_1010;
    walk(20'hFFC01, 20'hFFFFF, 2, 32'h00000401, 32'h2AF37853, 1'b0, 1'b0,
         32'hFFFFFFFC, 32'h00001004, leaf_e(1'b0, 20'hABCDE, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0);

    // Reset while waiting for a PTE, then a stale response
    io_req_valid = 1'b1; io_req_vpn = 20'h12345; io_satp_ppn = 20'h00080;
    tick();
    io_req_valid = 1'b0;
    for (int k = 0; k < 20 && io_mem_req_valid !== 1'b1; k++) tick();
    check("rw_mreq_valid", io_mem_req_valid, 1'b1);
    io_mem_req_ready = 1'b1;
    tick();
    io_mem_req_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_req_ready", io_req_ready, 1'b1);
    check("rw_mreq_valid_off", io_mem_req_valid, 1'b0);
    io_mem_resp_valid = 1'b1; io_mem_resp_data = 32'h1000004B;
    tick();
    io_mem_resp_valid = 1'b0;
    repeat (3) begin
      tick();
      check("rw_no_resp", io_resp_valid, 1'b0);
      check("rw_idle", io_req_ready, 1'b1);
    end
    walk(20'h12345, 20'h00080, 2, 32'h20000001, 32'h123450CF, 1'b0, 1'b0,
         32'h00080120, 32'h80000D14, leaf_e(1'b0, 20'h48D14, 1'b0, 1'b1, 1'b1, 1'b1), 1'b0);

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sv32_ptw_refill.md
Name: sv32_ptw_refill

Overview:
- Single-walker Sv32 page-table walker that produces TLB refill entries.
- Accepts a 20-bit VPN miss from the TLB and fetches up to two 32-bit PTEs over a simple valid/ready memory port.
- Returns the entry field set the TLB stores: ppn, u, ae_ptw, ae_final, pf, gf, sw, sx, sr, pw, px, pr, ppp, pal, paa, eff, c.
- Sits between the L1 TLB refill path and the data-cache/PTW memory arbiter.

Parameters:
- PTE_BYTES, 4, PTE size in bytes; fixed for Sv32, used for index scaling.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- io_req_valid  in  1  TLB miss request
- io_req_ready  out  1  walker idle and able to accept
- io_req_vpn  in  20  virtual page number
- io_satp_ppn  in  20  root table PPN; sampled at request accept
- io_mem_req_valid  out  1  PTE fetch request
- io_mem_req_ready  in  1  memory accepts fetch
- io_mem_req_addr  out  32  PTE physical address
- io_mem_resp_valid  in  1  PTE data returned
- io_mem_resp_data  in  32  PTE
- io_mem_resp_ae  in  1  access error on the fetch
- io_pma_r, io_pma_w, io_pma_x  in  1 each  PMA permissions for the final PPN
- io_pma_ppp, io_pma_pal, io_pma_paa, io_pma_eff, io_pma_c  in  1 each  PMA attributes for the final PPN
- io_resp_valid  out  1  refill entry valid
- io_resp_ready  in  1  TLB consumes entry
- io_resp_level  out  1  1 = 4 MiB superpage leaf, 0 = 4 KiB leaf
- io_resp_ppn  out  20  entry PPN
- io_resp_u, io_resp_ae_ptw, io_resp_ae_final, io_resp_pf, io_resp_gf, io_resp_sw, io_resp_sx, io_resp_sr, io_resp_pw, io_resp_px, io_resp_pr, io_resp_ppp, io_resp_pal, io_resp_paa, io_resp_eff, io_resp_c  out  1 each  entry fields

Behaviour:
- States: IDLE, MREQ, MWAIT, RESP. Reset value is IDLE.
- Reset values: all outputs 0, except io_req_ready = 1.
- IDLE:
  - io_req_ready = 1.
  - On io_req_valid: latch the VPN, set level = 1, set table = io_satp_ppn, go to MREQ.
- MREQ:
  - io_mem_req_valid = 1.
  - io_mem_req_addr = {table, 12'b0} + (level ? vpn[19:10] : vpn[9:0]) * 4.
  - Address is held stable until io_mem_req_ready. The req_valid && req_ready cycle moves to MWAIT.
- MWAIT:
  - Waits any number of cycles for io_mem_resp_valid. Decode in that cycle:
  - ae = 1: ae_ptw = 1 if the PTE is non-leaf-capable (level 1), else ae_final = 1. Go to RESP with all permissions 0.
  - V = 0, or (W = 1 and R = 0), or PTE[31:30] != 0: set pf = 1, go to RESP.
  - Leaf (R|X) at level 1 with PTE[19:10] != 0 (misaligned superpage): pf = 1.
  - Leaf (R|X), no fault: go to RESP.
  - Non-leaf at level 1: set table = PTE[29:10], level = 0, go to MREQ.
  - Non-leaf at level 0: pf = 1.
- Leaf entry fields:
  - ppn = level ? {PTE[29:20], vpn[9:0]} : PTE[29:10]
  - u = PTE.U
  - sr = R & A
  - sw = W & D & A
  - sx = X & A
  - pr/pw/px and ppp/pal/paa/eff/c = PMA inputs sampled in the leaf-decode cycle
  - gf = 0 always
- Any fault (pf or ae): ppn = 0, and all permission and attribute fields = 0.
- RESP:
  - io_resp_valid = 1; all io_resp_* are registered and stable until io_resp_ready.
  - The handshake cycle returns to IDLE; io_req_ready rises the following cycle.
- Exactly one of {clean leaf, pf, ae_ptw, ae_final} describes each response.
- io_mem_resp_valid outside MWAIT is ignored, including stale responses after reset.
- Reset mid-walk: return to IDLE next cycle, drop the outstanding fetch, deassert all valids.
- Address arithmetic is 32-bit, with no carry beyond bit 31.

Test Plan:
- 4 KiB walk:
  - satp_ppn = 0x00080, vpn = 0x12345.
  - Level-1 fetch at 0x00080120 returns 0x20000001 (non-leaf, ppn 0x80000).
  - Level-0 fetch at 0x80000D14 returns 0x123450CF (V R W X A D).
  - Required response: ppn = 0x48D14 (PTE[29:10]), level = 0, sr = sw = sx = 1, u = 0, pf = 0.
- Superpage:
  - Level-1 PTE 0x1000004B (V R X A).
  - Required response: level = 1, ppn = {0x100, vpn[9:0]}, sw = 0, sx = 1.
- Misaligned superpage:
  - Level-1 leaf PTE with PTE[19:10] = 0x001.
  - Required response: pf = 1, ppn = 0, all permissions 0.
- Access error:
  - mem_resp_ae = 1 on the level-1 fetch → ae_ptw = 1.
  - mem_resp_ae = 1 on the level-0 fetch → ae_final = 1.
- Backpressure:
  - Hold mem_req_ready = 0 for 5 cycles → address stable throughout.
  - Hold resp_ready = 0 for 3 cycles → entry fields stable.
  - req_ready = 0 throughout; a second req_valid is not accepted.
- Reset during MWAIT:
  - Assert reset, then deliver a late mem_resp_valid.
  - Required: walker stays IDLE, no resp_valid; a fresh walk then completes normally.
